// File: rtl/gcd_pkg.sv
// ============================================================
// Package : gcd_pkg
// Shared FSM encoding and default sizing for the GCD dispatcher.
// Rev     : 1.0
// ============================================================
`default_nettype none

package gcd_pkg;

    localparam int GCD_W       = 8;
    localparam int GCD_DEPTH   = 4;
    localparam int GCD_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/gcd_fifo.sv
// ============================================================
// Module : gcd_fifo
// Synchronous operand-pair FIFO, DEPTH entries (power of two).
// Rev    : 1.0
// ============================================================
`default_nettype none

module gcd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [2*W-1:0]               push_data,
    input  logic                         pop,
    output logic [2*W-1:0]               pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [2*W-1:0] mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/gcd_dispatch.sv
// ============================================================
// Module : gcd_dispatch
// Queues operand pairs and issues them one at a time to a GCD engine.
// Rev    : 1.0
// ============================================================
`default_nettype none

module gcd_dispatch
    import gcd_pkg::*;
#(
    parameter int W       = GCD_W,
    parameter int DEPTH   = GCD_DEPTH,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 in_a,
    input  logic [W-1:0]                 in_b,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_y,
    output logic                         out_error,
    output logic                         out_timeout,
    output logic                         gcd_start,
    output logic [W-1:0]                 gcd_a,
    output logic [W-1:0]                 gcd_b,
    input  logic                         gcd_done,
    input  logic [W-1:0]                 gcd_y,
    input  logic                         gcd_error,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int TW = $clog2(TIMEOUT+1);

    state_t          state;
    state_t          state_d;
    logic            full;
    logic            empty;
    logic [2*W-1:0]  head;
    logic            gcd_done_q;
    logic            done_edge;
    logic [TW-1:0]   tcnt;
    logic            tmo_hit;
    logic            launch;

    gcd_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_valid && in_ready),
        .push_data ({in_a, in_b}),
        .pop       (state == ISSUE),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign in_ready  = !full;
    assign busy      = (state != IDLE);
    assign done_edge = gcd_done && !gcd_done_q;
    assign launch    = (state == IDLE) && !empty;
    // Fires in the cycle the counter would step onto TIMEOUT.
    assign tmo_hit   = (tcnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (!empty) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (done_edge || tmo_hit) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcd_done_q  <= 1'b0;
            gcd_start   <= 1'b0;
            gcd_a       <= '0;
            gcd_b       <= '0;
            tcnt        <= '0;
            out_valid   <= 1'b0;
            out_y       <= '0;
            out_error   <= 1'b0;
            out_timeout <= 1'b0;
        end else begin
            gcd_done_q <= gcd_done;
            gcd_start  <= launch;
            // Operands latch on entry to ISSUE and stay put for the engine.
            if (launch) begin
                {gcd_a, gcd_b} <= head;
            end
            if (state == ISSUE) begin
                tcnt <= '0;
            end else if (state == WAIT) begin
                tcnt <= tcnt + TW'(1);
            end
            if (state == WAIT) begin
                if (done_edge) begin
                    out_y       <= gcd_y;
                    out_error   <= gcd_error;
                    out_timeout <= 1'b0;
                    out_valid   <= 1'b1;
                end else if (tmo_hit) begin
                    out_y       <= '0;
                    out_error   <= 1'b1;
                    out_timeout <= 1'b1;
                    out_valid   <= 1'b1;
                end
            end else if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
